// File: rtl/imem_boot_loader_if.sv
// Word-stream plus byte-write bus shared by the boot loader and its host/memory.
// Ports: in_valid/in_data/in_ready form the word stream; mem_we/mem_addr/mem_wdata form the byte write port.
// The slave modport is the loader's view; the master modport is the host/memory side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Purpose: loads NUM_WORDS instruction words into byte-wide imem, holding the core in reset until done.
// Latency: word accepted at edge k -> byte writes on cycles k+1..k+4; next in_ready (or done) on k+5.
// Backpressure: in_ready only in WAIT_WORD, so at most one word per 5 cycles; in_valid is ignored otherwise.
// Ports: clk, rst (async active-low), start pulse, bus (word stream in, byte write out),
//        core_rst_n / busy / done status, word_count = words accepted in the current load.
module imem_boot_loader #(
  parameter int NUM_WORDS = 22,
  parameter int ADDR_W    = 8,
  parameter int WCNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_boot_loader_if.slave bus,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic [WCNT_W-1:0] word_count
);

  if (NUM_WORDS < 1) begin : g_chk_num_words
    $error("imem_boot_loader: NUM_WORDS must be at least 1");
  end
  if ((2 ** ADDR_W) < (4 * NUM_WORDS)) begin : g_chk_addr_w
    $error("imem_boot_loader: ADDR_W too small for 4*NUM_WORDS bytes");
  end
  if ((2 ** WCNT_W) <= NUM_WORDS) begin : g_chk_wcnt_w
    $error("imem_boot_loader: WCNT_W cannot hold NUM_WORDS");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [1:0]        byte_idx;
  logic [31:0]       word_reg;

  logic [1:0]        idx_inc;
  logic [WCNT_W-1:0] wc_inc;

  assign idx_inc = byte_idx + 2'd1;
  assign wc_inc  = word_count + 1'b1;

  // Outputs are registered alongside the state: each transition loads the
  // output values that belong to the state being entered. While in WRITE the
  // address/data for the *next* byte are precomputed from idx_inc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      word_count    <= '0;
      byte_idx      <= '0;
      word_reg      <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      core_rst_n    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= WAIT_WORD;
            word_count   <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end

        WAIT_WORD: begin
          if (bus.in_valid && bus.in_ready) begin
            state         <= WRITE;
            word_reg      <= bus.in_data;
            byte_idx      <= 2'd0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ADDR_W'({word_count, 2'b00});
            bus.mem_wdata <= bus.in_data[7:0];
          end
        end

        WRITE: begin
          byte_idx <= idx_inc;
          if (byte_idx == 2'd3) begin
            word_count    <= wc_inc;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            if (wc_inc == WCNT_W'(NUM_WORDS)) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state        <= WAIT_WORD;
              bus.in_ready <= 1'b1;
            end
          end else begin
            bus.mem_addr  <= ADDR_W'({word_count, idx_inc});
            bus.mem_wdata <= word_reg[{idx_inc, 3'b000} +: 8];
          end
        end

        DONE: begin
          // Restart is a full reload: core goes back into reset first.
          if (start) begin
            state        <= WAIT_WORD;
            word_count   <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            core_rst_n   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;

  always #5 clk = ~clk;

  // Main instance: 22-word image
  imem_boot_loader_if #(.ADDR_W(8)) bus ();
  logic       core_rst_n, busy, done;
  logic [4:0] word_count;

  imem_boot_loader #(.NUM_WORDS(22), .ADDR_W(8), .WCNT_W(5)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus.slave),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  // Second instance: single-word image
  imem_boot_loader_if #(.ADDR_W(4)) bus1 ();
  logic       core_rst_n1, busy1, done1;
  logic [0:0] word_count1;

  imem_boot_loader #(.NUM_WORDS(1), .ADDR_W(4), .WCNT_W(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .bus        (bus1.slave),
    .core_rst_n (core_rst_n1),
    .busy       (busy1),
    .done       (done1),
    .word_count (word_count1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int w, input int b);
    return 8'((4 * w + b) * 7 + 1);
  endfunction

  function automatic logic [31:0] word_of(input int w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = byte_of(w, b);
    return r;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},   bus.in_ready,  0);
    chk({tag, "_mem_we"},     bus.mem_we,    0);
    chk({tag, "_mem_addr"},   bus.mem_addr,  0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata, 0);
    chk({tag, "_core_rst_n"}, core_rst_n,    0);
    chk({tag, "_busy"},       busy,          0);
    chk({tag, "_done"},       done,          0);
    chk({tag, "_word_count"}, word_count,    0);
  endtask

  // Called at a post-edge point while the main DUT waits for word w.
  // gap idle cycles precede the word; start is pulsed during byte start_byte;
  // rst is asserted during byte rst_byte (then the task returns early).
  task automatic send_word(input int w, input int gap, input int start_byte, input int rst_byte);
    chk("sw_in_ready", bus.in_ready, 1);
    chk("sw_word_count", word_count, w);
    for (int g = 0; g < gap; g++) begin
      chk("gap_mem_we", bus.mem_we, 0);
      chk("gap_word_count", word_count, w);
      tick();
    end
    chk("gap_end_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = word_of(w);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (b == rst_byte) begin
        chk("pre_rst_mem_we", bus.mem_we, 1);
        rst = 1'b0;
        #1;
        chk_reset("async_rst");
        #2;
        rst = 1'b1;
        return;
      end
      chk("wr_mem_we", bus.mem_we, 1);
      chk("wr_mem_addr", bus.mem_addr, 4 * w + b);
      chk("wr_mem_wdata", bus.mem_wdata, byte_of(w, b));
      chk("wr_in_ready", bus.in_ready, 0);
      if (b == start_byte) start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] exp1 [4];
    int hs;
    int ec;
    logic exp_rdy, exp_we;

    exp1[0] = 8'h13; exp1[1] = 8'h01; exp1[2] = 8'h50; exp1[3] = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 32'h0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk_reset("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset("idle");

    // Single word on the one-word instance
    start1 = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 32'h00500113;
    tick();
    start1 = 1'b0;
    chk("w1_in_ready", bus1.in_ready, 1);
    chk("w1_core_rst_n", core_rst_n1, 0);
    chk("w1_busy", busy1, 1);
    tick();
    bus1.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("w1_mem_we", bus1.mem_we, 1);
      chk("w1_mem_addr", bus1.mem_addr, b);
      chk("w1_mem_wdata", bus1.mem_wdata, exp1[b]);
      tick();
    end
    chk("w1_done", done1, 1);
    chk("w1_core_rst_n_up", core_rst_n1, 1);
    chk("w1_busy_low", busy1, 0);
    chk("w1_mem_we_low", bus1.mem_we, 0);
    chk("w1_word_count", word_count1, 1);
    // in_valid in DONE is ignored
    bus1.in_valid = 1'b1;
    tick();
    chk("w1_done_valid_we", bus1.mem_we, 0);
    tick();
    bus1.in_valid = 1'b0;
    chk("w1_done_valid_we2", bus1.mem_we, 0);
    chk("w1_done_held", done1, 1);

    // Full 22-word image, in_valid held high; cycle c counts from the start edge
    bus.in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    for (int c = 1; c <= 112; c++) begin
      exp_rdy = ((c % 5) == 1) && (c < 111);
      exp_we  = (c >= 2) && (c <= 110) && (((c - 1) % 5) != 0);
      ec = (c - 1) / 5;
      chk("full_in_ready", bus.in_ready, exp_rdy);
      chk("full_mem_we", bus.mem_we, exp_we);
      chk("full_done", done, c >= 111);
      chk("full_core_rst_n", core_rst_n, c >= 111);
      chk("full_busy", busy, c < 111);
      chk("full_word_count", word_count, (ec > 22) ? 22 : ec);
      if (exp_we) begin
        chk("full_mem_addr", bus.mem_addr, c - 2 - (c - 2) / 5);
        chk("full_mem_wdata", bus.mem_wdata, byte_of((c - 2) / 5, (c - 2) % 5));
      end else begin
        chk("full_idle_addr", bus.mem_addr, 0);
      end
      bus.in_data = word_of(hs);
      if (exp_rdy) hs++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("full_handshakes", hs, 22);

    // Start in DONE: full reload
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("reload_core_rst_n", core_rst_n, 0);
    chk("reload_done", done, 0);
    chk("reload_word_count", word_count, 0);
    chk("reload_busy", busy, 1);

    // Gapped words; start during WRITE of word 2; rst during byte 2 of word 3
    send_word(0, 3, -1, -1);
    send_word(1, 3, -1, -1);
    send_word(2, 3, 1, -1);
    chk("start_ignored_word_count", word_count, 3);
    chk("start_ignored_busy", busy, 1);
    send_word(3, 3, -1, 2);
    tick();
    chk_reset("after_rst");

    // New start after the abort reloads from address 0
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(0, 0, -1, -1);
    chk("post_abort_word_count", word_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller for the single-cycle RISC-V core's byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and splits each word into four little-endian byte writes. It holds the core in reset until the full program image is written, then releases it. It replaces direct hierarchical loading of the instruction memory, giving synthesizable program loading with a defined handoff to the core.

## Interface
- NUM_WORDS, 22, number of 32-bit instruction words in the image; must be ≥ 1
- ADDR_W, 8, byte-address width of the instruction memory; must satisfy 2^ADDR_W ≥ 4·NUM_WORDS (elaboration-time check, `$error` on violation)
- WCNT_W, 5, width of word counter; must satisfy 2^WCNT_W > NUM_WORDS (i.e. counter can hold NUM_WORDS)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins a load sequence
- in_valid  input  1  instruction word valid
- in_data  input  32  instruction word
- in_ready  output  1  loader can accept a word this cycle
- mem_we  output  1  instruction memory byte write enable
- mem_addr  output  ADDR_W  byte address of the current write
- mem_wdata  output  8  byte being written
- core_rst_n  output  1  active-low reset to the core; 0 while loading
- busy  output  1  load sequence in progress
- done  output  1  full image written; core released
- word_count  output  WCNT_W  words accepted in the current load

## Operation
- State machine has four states: IDLE, WAIT_WORD, WRITE, DONE. State, word counter, 2-bit byte index and 32-bit word register are all flops.
- Reset (rst=0, asynchronous) forces the following values: state=IDLE, word_count=0, byte index=0, word register=0.
- Reset output values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0.
- IDLE:
  - core_rst_n=0.
  - start=1 → WAIT_WORD; word_count cleared to 0.
- WAIT_WORD:
  - in_ready=1, busy=1.
  - Handshake (in_valid & in_ready) → latch in_data, set byte index=0, go to WRITE.
  - in_valid without a handshake has no effect.
- WRITE:
  - busy=1, in_ready=0, mem_we=1.
  - mem_addr = 4·word_count + byte index, truncated to ADDR_W.
  - mem_wdata = word[8·idx +: 8]. Byte 0 is bits [7:0] (little-endian).
  - Byte index increments each cycle.
  - After idx=3: word_count increments. If the new count equals NUM_WORDS → DONE, else → WAIT_WORD.
- DONE:
  - done=1, core_rst_n=1, busy=0, in_ready=0, mem_we=0.
  - start=1 → core_rst_n returns to 0 in the next cycle, word_count clears, state goes to WAIT_WORD (full reload).
- Ignored inputs:
  - start in WAIT_WORD or WRITE is ignored; the sequence is not restarted.
  - in_valid in IDLE, WRITE or DONE is ignored because in_ready=0.
- Address/data outputs: mem_addr and mem_wdata are driven only meaningfully when mem_we=1; they read 0 otherwise.
- All outputs are decoded from registered state; there are no combinational input-to-output paths except none.

## Timing
- Word handshake at edge k → byte writes occur on cycles k+1 through k+4, one write per cycle.
- in_ready reasserts on cycle k+5 (WAIT_WORD), or the block enters DONE on cycle k+5 after the last word.
- Peak throughput is one word per 5 cycles.
- Minimum load time from start is 1 + 5·NUM_WORDS cycles until done=1 and core_rst_n=1.
- core_rst_n rises in the same cycle done rises, and falls one cycle after start is sampled in DONE.
- Reset mid-load (any state) aborts immediately: core stays in reset and memory contents are left partial. A new start is required.

## Test plan
- Reset then start, single word 0x00500113, NUM_WORDS=1 → writes 13, 01, 50, 00 at addresses 0, 1, 2, 3 on 4 consecutive cycles. Then done=1 and core_rst_n=1 on the cycle after the byte at address 3.
- Full image with NUM_WORDS=22 and in_valid held high → 88 writes with addresses 0..87 ascending. in_ready has period 5. done asserts exactly 111 cycles after start.
- Gaps in in_valid (3 idle cycles between words) → no writes during the gaps. word_count holds its value, and the addresses stay contiguous.
- start pulsed during WRITE of word 2 → ignored: word_count continues 2 → 3 and there are no address jumps. in_valid pulsed while in DONE → no mem_we.
- rst driven low during WRITE byte 2 → all outputs go to reset values asynchronously before the next edge. A subsequent start reloads from address 0.
- start issued in DONE → core_rst_n=0 on the next cycle, word_count=0, and the first new write goes to address 0.
